arb4_rr_ctrl: RTL and testbench
===============================

ARB4_RR_CTRL -- requirements
Module: arb4_rr_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 8, max consecutive GRANT cycles per tenure; 0 = unlimited.
REQ-002 Parameter CNT_W, default 4, hold-counter width; MAX_HOLD SHALL be < 2^CNT_W.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en_n  input  1  active-low arbiter enable; 1 = all grants withdrawn.
REQ-006 req  input  4  active-high request, bit i = requester i.
REQ-007 gnt_n  output  4  active-low one-hot grant; 4'b1111 = no grant; registered.
REQ-008 gnt_idx  output  2  binary index of current grantee; registered.
REQ-009 gnt_vld  output  1  high while a grant is driven; registered.
REQ-010 timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD; registered.

Function
REQ-011 The block SHALL implement states IDLE, GRANT, GAP; all outputs SHALL be registered.
REQ-012 gnt_n SHALL equal ~(4'b0001 << gnt_idx) when gnt_vld=1 and 4'b1111 otherwise; never more than one bit low.
REQ-013 Arbitration SHALL be round-robin: search starts at (ptr+1) mod 4, wraps 3->0, picks first req bit set.
REQ-014 ptr SHALL update to the winner's index on every IDLE->GRANT or GAP->GRANT transition.
REQ-015 IDLE: en_n=0 and req!=0 -> GRANT next edge (1-cycle request-to-grant latency); else stay IDLE.
REQ-016 GRANT: grant held while req[gnt_idx]=1 (locked; other requests ignored).
REQ-017 GRANT: req[gnt_idx]=0 sampled -> GAP next edge; gnt_n=4'b1111, gnt_vld=0 in GAP.
REQ-018 GRANT: hold_cnt increments each GRANT cycle; when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with req still high -> GAP next edge and timeout=1 for exactly that GAP cycle.
REQ-019 hold_cnt SHALL clear on every entry to GRANT and SHALL not wrap during a tenure.
REQ-020 GAP SHALL last exactly one cycle; then arbitrate as IDLE (GRANT if en_n=0 and req!=0, else IDLE); release-to-next-grant = 2 edges.
REQ-021 A requester preempted by timeout SHALL regain the grant after GAP only if no other req bit is set (round-robin from its index).
REQ-022 en_n=1 sampled in any state -> IDLE next edge, outputs to idle values, ptr and timeout unaffected except timeout=0; no GAP inserted.
REQ-023 Simultaneous release and new requests: release wins; new requests arbitrated in GAP.
REQ-024 Request dropped in the same cycle it wins (IDLE arbitration) SHALL still produce one GRANT cycle, then GAP.
REQ-025 Grant SHALL never switch directly from one requester to another without at least one GAP or IDLE cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, gnt_n=4'b1111, gnt_idx=2'b00, gnt_vld=0, timeout=0, hold_cnt=0, ptr=2'b11 (requester 0 highest priority first).
REQ-027 Reset asserted mid-tenure SHALL drop the grant asynchronously; after release, first grant follows REQ-026 priority.
REQ-028 Deassertion of rst_n SHALL take effect at the first following rising edge of clk.

Verification
REQ-029 After reset, en_n=0, req=4'b1111 held, MAX_HOLD=8 -> gnt_n sequence 1110,1101,1011,0111,1110, each 8 cycles, separated by one 1111 cycle with timeout=1.
REQ-030 req=4'b0100 one cycle from IDLE -> gnt_n=1011, gnt_idx=2, gnt_vld=1 for one cycle, then 1111 (GAP), then IDLE.
REQ-031 Requester 1 granted, drops req while req=4'b1001 pending -> GAP one cycle, then gnt_n=0111 (idx 3 before idx 0).
REQ-032 Only req[2]=1 held, MAX_HOLD=3 -> 3 cycles gnt_n=1011, 1 cycle 1111 with timeout=1, regranted, repeating.
REQ-033 en_n=1 during GRANT of idx 0 -> next edge gnt_n=1111, gnt_vld=0, timeout=0; en_n back to 0 with req=4'b0011 -> grant idx 1.
REQ-034 rst_n pulsed low mid-GRANT -> gnt_n=1111 without clock edge; after release with req=4'b1010 -> grant idx 1.

Source files
------------

// File: rtl/arb4_rr_ctrl_if.sv
// Bundles the request/grant handshake of the 4-way round-robin arbiter.
// The master side drives enable and requests; the slave side (the arbiter) drives the grants.
interface arb4_rr_ctrl_if;
  logic       en_n;
  logic [3:0] req;
  logic [3:0] gnt_n;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  modport master (
    output en_n,
    output req,
    input  gnt_n,
    input  gnt_idx,
    input  gnt_vld,
    input  timeout
  );

  modport slave (
    input  en_n,
    input  req,
    output gnt_n,
    output gnt_idx,
    output gnt_vld,
    output timeout
  );
endinterface

// File: rtl/arb4_rr_ctrl.sv
// 4-requester round-robin arbiter with locked tenures, an optional hold limit
// and a mandatory one-cycle gap between tenures. All outputs are registered.
module arb4_rr_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  arb4_rr_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_gnt_n;
  logic [1:0]       r_gnt_idx;
  logic             r_gnt_vld;
  logic             r_timeout;

  logic [1:0]       w_win;
  logic             w_found;
  logic [1:0]       w_cand;
  logic             w_hold_limit;

  // Round-robin search: start one past the last winner, wrap 3->0, take the first set request.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_cand  = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_cand = 2'(int'(r_ptr) + k);
      if (!w_found && bus.req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // The current tenure has reached its last allowed cycle (never true when unlimited).
  always_comb begin
    w_hold_limit = 1'b0;
    if (MAX_HOLD != 0) begin
      w_hold_limit = (r_hold_cnt == HOLD_LAST);
    end
  end

  // Arbiter FSM: IDLE/GAP arbitrate, GRANT holds the lock until release, timeout or disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 2'b11;
      r_hold_cnt <= '0;
      r_gnt_n    <= 4'b1111;
      r_gnt_idx  <= 2'b00;
      r_gnt_vld  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (bus.en_n) begin
        r_state    <= IDLE;
        r_hold_cnt <= '0;
        r_gnt_n    <= 4'b1111;
        r_gnt_idx  <= 2'b00;
        r_gnt_vld  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE, GAP: begin
            if (w_found) begin
              r_state    <= GRANT;
              r_ptr      <= w_win;
              r_hold_cnt <= '0;
              r_gnt_n    <= ~(4'b0001 << w_win);
              r_gnt_idx  <= w_win;
              r_gnt_vld  <= 1'b1;
            end else begin
              r_state    <= IDLE;
              r_gnt_n    <= 4'b1111;
              r_gnt_idx  <= 2'b00;
              r_gnt_vld  <= 1'b0;
            end
          end
          GRANT: begin
            if (!bus.req[r_gnt_idx]) begin
              r_state   <= GAP;
              r_gnt_n   <= 4'b1111;
              r_gnt_vld <= 1'b0;
            end else if (w_hold_limit) begin
              r_state   <= GAP;
              r_gnt_n   <= 4'b1111;
              r_gnt_vld <= 1'b0;
              r_timeout <= 1'b1;
            end else if (r_hold_cnt != HOLD_SAT) begin
              r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state   <= IDLE;
            r_gnt_n   <= 4'b1111;
            r_gnt_idx <= 2'b00;
            r_gnt_vld <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.gnt_n   = r_gnt_n;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed scoreboard bench for arb4_rr_ctrl: instance A uses MAX_HOLD=8, instance B MAX_HOLD=3.
module tb_arb4_rr_ctrl;

  typedef struct {
    bit         sel;
    logic [3:0] gn;
    logic       vld;
    logic       to;
    int         n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   stepNo = 0;
  exp_t sb[$];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  arb4_rr_ctrl_if busA ();
  arb4_rr_ctrl_if busB ();

  arb4_rr_ctrl #(.MAX_HOLD(8), .CNT_W(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  arb4_rr_ctrl #(.MAX_HOLD(3), .CNT_W(4)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  // Index of the single low bit in an expected active-low grant vector.
  function automatic logic [1:0] idxOf(input logic [3:0] gn);
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (!gn[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Compare one DUT's outputs against expected values.
  task automatic compareOut(input bit sel, input logic [3:0] eg, input logic ev, input logic et,
                            input bit chkIdx, input logic [1:0] ei, input int n);
    logic [3:0] og;
    logic [1:0] oi;
    logic       ov;
    logic       ot;
    if (sel) begin
      og = busB.gnt_n; oi = busB.gnt_idx; ov = busB.gnt_vld; ot = busB.timeout;
    end else begin
      og = busA.gnt_n; oi = busA.gnt_idx; ov = busA.gnt_vld; ot = busA.timeout;
    end
    total++;
    assert (og === eg) else begin
      bad++;
      $error("[TB] FAIL gnt_n step=%0d dut=%0d observed=%b expected=%b", n, sel, og, eg);
    end
    total++;
    assert (ov === ev) else begin
      bad++;
      $error("[TB] FAIL gnt_vld step=%0d dut=%0d observed=%b expected=%b", n, sel, ov, ev);
    end
    total++;
    assert (ot === et) else begin
      bad++;
      $error("[TB] FAIL timeout step=%0d dut=%0d observed=%b expected=%b", n, sel, ot, et);
    end
    if (chkIdx) begin
      total++;
      assert (oi === ei) else begin
        bad++;
        $error("[TB] FAIL gnt_idx step=%0d dut=%0d observed=%0d expected=%0d", n, sel, oi, ei);
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rise.
  task automatic applyStimulus(input bit sel, input logic en, input logic [3:0] rq,
                               input logic [3:0] eg, input logic ev, input logic et);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      busB.en_n = en; busB.req = rq;
    end else begin
      busA.en_n = en; busA.req = rq;
    end
    stepNo++;
    e.sel = sel; e.gn = eg; e.vld = ev; e.to = et; e.n = stepNo;
    sb.push_back(e);
  endtask

  // Wait for the rising edge, then pop the oldest expectation and compare.
  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard empty observed=0 entries expected>=1");
    end else begin
      e = sb.pop_front();
      compareOut(e.sel, e.gn, e.vld, e.to, e.vld, idxOf(e.gn), e.n);
    end
  endtask

  task automatic step(input bit sel, input logic en, input logic [3:0] rq,
                      input logic [3:0] eg, input logic ev, input logic et);
    applyStimulus(sel, en, rq, eg, ev, et);
    checkOutput();
  endtask

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [3:0] g;
    rst_n = 1'b1;
    busA.en_n = 1'b1; busA.req = 4'b0000;
    busB.en_n = 1'b1; busB.req = 4'b0000;
    #1 rst_n = 1'b0;
    #2;
    compareOut(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'b00, 0);
    compareOut(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'b00, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single requester held, MAX_HOLD=3, then preempted with another pending");
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 4'b0100, 4'b1011, 1'b1, 1'b0);
      step(1'b1, 1'b0, 4'b0100, 4'b1111, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 4'b0100, 4'b1011, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0101, 4'b1011, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0101, 4'b1011, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0101, 4'b1111, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'b0101, 4'b1110, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);

    $display("[TB] all four requesting, MAX_HOLD=8 rotation");
    for (int k = 0; k < 5; k++) begin
      g = ~(4'b0001 << (k % 4));
      for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 4'b1111, g, 1'b1, 1'b0);
      if (k < 4) step(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1);
    end

    $display("[TB] disable during grant, re-enable");
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0011, 4'b1101, 1'b1, 1'b0);

    $display("[TB] release with others pending");
    step(1'b0, 1'b0, 4'b1001, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b1001, 4'b0111, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);

    $display("[TB] one-cycle request from idle");
    step(1'b0, 1'b0, 4'b0100, 4'b1011, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);

    $display("[TB] release coincident with new request");
    step(1'b0, 1'b0, 4'b0001, 4'b1110, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0010, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0010, 4'b1101, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-grant");
    step(1'b0, 1'b0, 4'b0100, 4'b1011, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    busA.req = 4'b0000;
    #1;
    compareOut(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'b00, -1);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 4'b1010, 4'b1101, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b1010, 4'b1101, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
